// File: rtl/mem_rd_credit_gate_if.sv
// mem_rd_credit_gate_if
//   Read-request channel from the credit gate to the TX TLP builder.
//   master : the gate (drives valid/addr/len/tag/src, samples ready)
//   slave  : the TX builder (samples the request, drives ready)
//   o_TxRdValid   request valid
//   i_TxRdReady   TX accepts when valid & ready
//   o64_TxRdAddr  byte address of the granted read
//   o10_TxRdLen   length in DW (0 = 1024 DW)
//   o5_TxRdTag    tag, increments mod 32 per accepted read
//   o3_TxRdSrc    index of the granted requestor
interface mem_rd_credit_gate_if;
  logic        o_TxRdValid;
  logic        i_TxRdReady;
  logic [63:0] o64_TxRdAddr;
  logic [9:0]  o10_TxRdLen;
  logic [4:0]  o5_TxRdTag;
  logic [2:0]  o3_TxRdSrc;

  modport master (
    output o_TxRdValid, o64_TxRdAddr, o10_TxRdLen, o5_TxRdTag, o3_TxRdSrc,
    input  i_TxRdReady
  );

  modport slave (
    input  o_TxRdValid, o64_TxRdAddr, o10_TxRdLen, o5_TxRdTag, o3_TxRdSrc,
    output i_TxRdReady
  );
endinterface

// File: rtl/mem_rd_credit_gate.sv
// mem_rd_credit_gate
//   Round-robin arbiter for memory-read requests from pREQUESTOR_NUM DMA requestors.
//   Computes the completion header/data credits (CH/CD) of the granted read and only
//   issues it to TX once the downstream credit tracker reports enough credit. After
//   each accepted read a one-cycle submit pulse carries CH/CD to the tracker, followed
//   by two cool-down cycles so the tracker can settle before the next compare.
// Ports
//   i_Clk / i_ARstN          clock, asynchronous active-low reset
//   iv_RdReqValid/Addr/Len   per-requestor request (held until ack)
//   ov_RdReqAck              one-cycle accept pulse, same cycle as the TX handshake
//   txRd                     TX read channel (mem_rd_credit_gate_if.master)
//   ov_MemRdReqSubmit/CH/CD  to tracker: one-hot submit with this read's credits
//   i8_AvailCredCH/CD        from tracker: available credits
//   i8_TotalCredCH/CD        advertised totals (only with MEM_RD_CREDIT_GATE_INFINITE_EN)
// Build option
//   MEM_RD_CREDIT_GATE_INFINITE_EN : a total of 0 means infinite credit for that type.
//
// state | meaning
// IDLE  | wait for any valid, latch round-robin winner
// CALC  | compute CH/CD of the latched request
// CHECK | wait until available credit covers CH and CD (head-of-line)
// ISSUE | TX valid held until ready; ack pulses on handshake
// COOL1 | submit pulse to tracker
// COOL2 | tracker settling
// COOL3 | tracker settling
module mem_rd_credit_gate #(
  parameter int pREQUESTOR_NUM = 2,
  parameter int pRCB_LOG2      = 6
) (
  input  logic                         i_Clk,
  input  logic                         i_ARstN,
  input  logic [pREQUESTOR_NUM-1:0]    iv_RdReqValid,
  input  logic [pREQUESTOR_NUM*64-1:0] iv_RdReqAddr,
  input  logic [pREQUESTOR_NUM*10-1:0] iv_RdReqLen,
  output logic [pREQUESTOR_NUM-1:0]    ov_RdReqAck,
  mem_rd_credit_gate_if.master         txRd,
  output logic [pREQUESTOR_NUM-1:0]    ov_MemRdReqSubmit,
  output logic [pREQUESTOR_NUM*8-1:0]  ov_MemRdReqCH,
  output logic [pREQUESTOR_NUM*12-1:0] ov_MemRdReqCD,
  input  logic [7:0]                   i8_AvailCredCH,
  input  logic [11:0]                  i12_AvailCredCD,
  input  logic [7:0]                   i8_TotalCredCH,
  input  logic [11:0]                  i12_TotalCredCD
);

  localparam logic [12:0] cRcbMask = 13'((1 << pRCB_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, CALC, CHECK, ISSUE, COOL1, COOL2, COOL3} state_t;

  state_t      state;
  logic [2:0]  srcQ;
  logic [2:0]  rrPtr;
  logic [63:0] addrQ;
  logic [9:0]  lenQ;
  logic [4:0]  tagQ;
  logic [7:0]  chQ;
  logic [11:0] cdQ;
  logic        txValidQ;
  logic [pREQUESTOR_NUM-1:0]    submitQ;
  logic [pREQUESTOR_NUM*8-1:0]  subChQ;
  logic [pREQUESTOR_NUM*12-1:0] subCdQ;

  // Round-robin: first pass covers indices above the last grant, second pass wraps.
  logic        winFound;
  logic [2:0]  winIdx;
  logic [63:0] winAddr;
  logic [9:0]  winLen;

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    winAddr  = '0;
    winLen   = '0;
    for (int j = 0; j < pREQUESTOR_NUM; j++) begin
      if (!winFound && iv_RdReqValid[j] && (3'(j) > rrPtr)) begin
        winFound = 1'b1;
        winIdx   = 3'(j);
        winAddr  = iv_RdReqAddr[j*64 +: 64];
        winLen   = iv_RdReqLen[j*10 +: 10];
      end
    end
    for (int j = 0; j < pREQUESTOR_NUM; j++) begin
      if (!winFound && iv_RdReqValid[j] && (3'(j) <= rrPtr)) begin
        winFound = 1'b1;
        winIdx   = 3'(j);
        winAddr  = iv_RdReqAddr[j*64 +: 64];
        winLen   = iv_RdReqLen[j*10 +: 10];
      end
    end
  end

  // 13 bits holds the worst case: 127 + 4096 + 127 for a 128B RCB.
  logic [12:0] bytes;
  logic [12:0] cdSum;
  logic [12:0] chSum;
  logic [12:0] cdCalc;
  logic [12:0] chCalc;

  always_comb begin
    bytes  = (lenQ == 10'd0) ? 13'd4096 : {1'b0, lenQ, 2'b00};
    cdSum  = bytes + 13'd15;
    chSum  = (13'(addrQ[pRCB_LOG2-1:0])) + bytes + cRcbMask;
    cdCalc = cdSum >> 4;
    chCalc = chSum >> pRCB_LOG2;
  end

  logic chOk;
  logic cdOk;
`ifdef MEM_RD_CREDIT_GATE_INFINITE_EN
  assign chOk = (i8_TotalCredCH == 8'd0)   || (chQ <= i8_AvailCredCH);
  assign cdOk = (i12_TotalCredCD == 12'd0) || (cdQ <= i12_AvailCredCD);
`else
  assign chOk = (chQ <= i8_AvailCredCH);
  assign cdOk = (cdQ <= i12_AvailCredCD);
  logic unusedTotals;
  assign unusedTotals = ^{i8_TotalCredCH, i12_TotalCredCD};
`endif

  logic handshake;
  assign handshake = txValidQ && txRd.i_TxRdReady;

  always_comb begin
    ov_RdReqAck = '0;
    for (int j = 0; j < pREQUESTOR_NUM; j++)
      ov_RdReqAck[j] = handshake && (srcQ == 3'(j));
  end

  always_ff @(posedge i_Clk or negedge i_ARstN) begin
    if (!i_ARstN) begin
      state    <= IDLE;
      srcQ     <= '0;
      rrPtr    <= '0;
      addrQ    <= '0;
      lenQ     <= '0;
      tagQ     <= '0;
      chQ      <= '0;
      cdQ      <= '0;
      txValidQ <= 1'b0;
      submitQ  <= '0;
      subChQ   <= '0;
      subCdQ   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winFound) begin
            srcQ  <= winIdx;
            addrQ <= winAddr;
            lenQ  <= winLen;
            state <= CALC;
          end
        end
        CALC: begin
          chQ   <= chCalc[7:0];
          cdQ   <= cdCalc[11:0];
          state <= CHECK;
        end
        CHECK: begin
          if (chOk && cdOk) begin
            txValidQ <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (txRd.i_TxRdReady) begin
            txValidQ <= 1'b0;
            tagQ     <= tagQ + 5'd1;
            rrPtr    <= srcQ;
            for (int j = 0; j < pREQUESTOR_NUM; j++) begin
              submitQ[j]         <= (srcQ == 3'(j));
              subChQ[j*8 +: 8]   <= (srcQ == 3'(j)) ? chQ : 8'd0;
              subCdQ[j*12 +: 12] <= (srcQ == 3'(j)) ? cdQ : 12'd0;
            end
            state <= COOL1;
          end
        end
        COOL1: begin
          submitQ <= '0;
          subChQ  <= '0;
          subCdQ  <= '0;
          state   <= COOL2;
        end
        COOL2:   state <= COOL3;
        COOL3:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign txRd.o_TxRdValid  = txValidQ;
  assign txRd.o64_TxRdAddr = addrQ;
  assign txRd.o10_TxRdLen  = lenQ;
  assign txRd.o5_TxRdTag   = tagQ;
  assign txRd.o3_TxRdSrc   = srcQ;

  assign ov_MemRdReqSubmit = submitQ;
  assign ov_MemRdReqCH     = subChQ;
  assign ov_MemRdReqCD     = subCdQ;

endmodule

// File: tb/tb_mem_rd_credit_gate.sv
module tb_mem_rd_credit_gate;
  logic         clk;
  logic         rstN;
  logic [1:0]   reqValid;
  logic [127:0] reqAddr;
  logic [19:0]  reqLen;
  logic [1:0]   ack;
  logic [1:0]   submit;
  logic [15:0]  subCH;
  logic [23:0]  subCD;
  logic [7:0]   availCH;
  logic [11:0]  availCD;
  logic [7:0]   totalCH;
  logic [11:0]  totalCD;

  int nPass = 0;
  int nTotal = 0;
  logic [4:0] expTag = 5'd0;

  mem_rd_credit_gate_if txIf ();

  mem_rd_credit_gate #(.pREQUESTOR_NUM(2), .pRCB_LOG2(6)) dut (
    .i_Clk             (clk),
    .i_ARstN           (rstN),
    .iv_RdReqValid     (reqValid),
    .iv_RdReqAddr      (reqAddr),
    .iv_RdReqLen       (reqLen),
    .ov_RdReqAck       (ack),
    .txRd              (txIf),
    .ov_MemRdReqSubmit (submit),
    .ov_MemRdReqCH     (subCH),
    .ov_MemRdReqCD     (subCD),
    .i8_AvailCredCH    (availCH),
    .i12_AvailCredCD   (availCD),
    .i8_TotalCredCH    (totalCH),
    .i12_TotalCredCD   (totalCD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request on requestor idx and follows it through TX and the submit pulse.
  task automatic issue_one(input int idx, input logic [63:0] addr, input logic [9:0] len,
                           input logic [7:0] expCH, input logic [11:0] expCD,
                           input int expLat, input string nm);
    int cnt;
    logic [1:0] oh;
    oh = 2'b01 << idx;
    reqAddr[idx*64 +: 64] = addr;
    reqLen[idx*10 +: 10]  = len;
    reqValid[idx]         = 1'b1;
    cnt = 0;
    while (!txIf.o_TxRdValid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    nTotal++;
    if (txIf.o_TxRdValid !== 1'b1) begin
      $display("FAIL %s_tx_valid_timeout: got %0b expected 1", nm, txIf.o_TxRdValid);
      reqValid[idx] = 1'b0;
      return;
    end else nPass++;
    if (expLat > 0) begin
      nTotal++;
      if (cnt !== expLat) $display("FAIL %s_latency: got %0d expected %0d", nm, cnt, expLat);
      else nPass++;
    end
    nTotal++;
    if (ack !== oh) $display("FAIL %s_ack: got %b expected %b", nm, ack, oh);
    else nPass++;
    nTotal++;
    if (txIf.o5_TxRdTag !== expTag) $display("FAIL %s_tag: got %0d expected %0d", nm, txIf.o5_TxRdTag, expTag);
    else nPass++;
    nTotal++;
    if (txIf.o3_TxRdSrc !== 3'(idx) || txIf.o64_TxRdAddr !== addr || txIf.o10_TxRdLen !== len)
      $display("FAIL %s_req_fields: got src %0d addr %0h len %0d expected src %0d addr %0h len %0d",
               nm, txIf.o3_TxRdSrc, txIf.o64_TxRdAddr, txIf.o10_TxRdLen, idx, addr, len);
    else nPass++;
    @(negedge clk);
    reqValid[idx] = 1'b0;
    expTag = expTag + 5'd1;
    nTotal++;
    if (submit !== oh || subCH[idx*8 +: 8] !== expCH || subCD[idx*12 +: 12] !== expCD)
      $display("FAIL %s_submit: got sub %b CH %0d CD %0d expected sub %b CH %0d CD %0d",
               nm, submit, subCH[idx*8 +: 8], subCD[idx*12 +: 12], oh, expCH, expCD);
    else nPass++;
    @(negedge clk);
    nTotal++;
    if (submit !== 2'b00 || subCH !== 16'h0 || subCD !== 24'h0)
      $display("FAIL %s_submit_clear: got sub %b CH %h CD %h expected all 0", nm, submit, subCH, subCD);
    else nPass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    reqValid = '0; reqAddr = '0; reqLen = '0;
    availCH = 8'd0; availCD = 12'd0; totalCH = 8'd8; totalCD = 12'd64;
    txIf.i_TxRdReady = 1'b0;
    repeat (2) @(negedge clk);
    nTotal++;
    if (txIf.o_TxRdValid !== 1'b0 || ack !== 2'b00 || submit !== 2'b00 || subCH !== 16'h0 ||
        subCD !== 24'h0 || txIf.o5_TxRdTag !== 5'd0 || txIf.o64_TxRdAddr !== 64'h0)
      $display("FAIL reset_outputs: got valid %b ack %b sub %b tag %0d addr %0h expected all 0",
               txIf.o_TxRdValid, ack, submit, txIf.o5_TxRdTag, txIf.o64_TxRdAddr);
    else nPass++;
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    availCH = 8'd8; availCD = 12'd64;
    txIf.i_TxRdReady = 1'b1;
    issue_one(0, 64'h1000, 10'd16, 8'd1, 12'd4, 3, "basic");
  endtask

  task automatic test_credit_calc();
    issue_one(0, 64'h1030, 10'd16, 8'd2, 12'd4, 0, "calc_unaligned");
    availCH = 8'd100; availCD = 12'd300;
    issue_one(0, 64'h0, 10'd0, 8'd64, 12'd256, 0, "calc_len0");
  endtask

  task automatic test_credit_stall();
    logic seen;
    availCH = 8'd8; availCD = 12'd3;
    reqAddr[64 +: 64] = 64'h4000; reqLen[10 +: 10] = 10'd16; reqValid[1] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | txIf.o_TxRdValid;
    end
    nTotal++;
    if (seen !== 1'b0) $display("FAIL stall_no_valid: got %b expected 0", seen);
    else nPass++;
    availCD = 12'd4;
    @(negedge clk);
    nTotal++;
    if (txIf.o_TxRdValid !== 1'b1) $display("FAIL stall_release_valid: got %b expected 1", txIf.o_TxRdValid);
    else nPass++;
    nTotal++;
    if (ack !== 2'b10 || txIf.o5_TxRdTag !== expTag)
      $display("FAIL stall_ack_tag: got ack %b tag %0d expected ack 10 tag %0d", ack, txIf.o5_TxRdTag, expTag);
    else nPass++;
    @(negedge clk);
    reqValid[1] = 1'b0;
    expTag = expTag + 5'd1;
    nTotal++;
    if (submit !== 2'b10 || subCD[12 +: 12] !== 12'd4 || subCH[8 +: 8] !== 8'd1)
      $display("FAIL stall_submit: got sub %b CH %0d CD %0d expected sub 10 CH 1 CD 4",
               submit, subCH[8 +: 8], subCD[12 +: 12]);
    else nPass++;
    repeat (4) @(negedge clk);
  endtask

  // Last grant went to requestor 1, so round-robin starts at 0.
  task automatic test_back_to_back();
    int cyc, nAck, nSub;
    int ackSrc[4];
    logic [4:0] ackTag[4];
    int subCyc[4];
    int subSrc[4];
    logic [11:0] subCdV[4];
    availCH = 8'd100; availCD = 12'd300;
    txIf.i_TxRdReady = 1'b1;
    reqAddr[0 +: 64]  = 64'h2000; reqLen[0 +: 10]  = 10'd8;
    reqAddr[64 +: 64] = 64'h3040; reqLen[10 +: 10] = 10'd32;
    reqValid = 2'b11;
    cyc = 0; nAck = 0; nSub = 0;
    while (nSub < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack != 2'b00 && nAck < 4) begin
        ackSrc[nAck] = (ack == 2'b10) ? 1 : ((ack == 2'b01) ? 0 : 9);
        ackTag[nAck] = txIf.o5_TxRdTag;
        nAck++;
        if (nAck == 4) reqValid = 2'b00;
      end
      if (submit != 2'b00) begin
        subCyc[nSub] = cyc;
        subSrc[nSub] = (submit == 2'b10) ? 1 : ((submit == 2'b01) ? 0 : 9);
        subCdV[nSub] = (submit == 2'b10) ? subCD[12 +: 12] : subCD[0 +: 12];
        nSub++;
      end
    end
    reqValid = 2'b00;
    nTotal++;
    if (nSub !== 4 || nAck !== 4) begin
      $display("FAIL b2b_timeout: got %0d acks %0d submits expected 4 and 4", nAck, nSub);
      return;
    end else nPass++;
    for (int k = 0; k < 4; k++) begin
      nTotal++;
      if (ackSrc[k] !== (k % 2) || ackTag[k] !== 5'(expTag + 5'(k)))
        $display("FAIL b2b_ack%0d: got src %0d tag %0d expected src %0d tag %0d",
                 k, ackSrc[k], ackTag[k], k % 2, 5'(expTag + 5'(k)));
      else nPass++;
      nTotal++;
      if (subSrc[k] !== (k % 2) || subCdV[k] !== ((k % 2 == 1) ? 12'd8 : 12'd2))
        $display("FAIL b2b_submit%0d: got src %0d CD %0d expected src %0d CD %0d",
                 k, subSrc[k], subCdV[k], k % 2, (k % 2 == 1) ? 8 : 2);
      else nPass++;
      if (k > 0) begin
        nTotal++;
        if (subCyc[k] - subCyc[k-1] < 5)
          $display("FAIL b2b_gap%0d: got %0d cycles expected >= 5", k, subCyc[k] - subCyc[k-1]);
        else nPass++;
      end
    end
    expTag = expTag + 5'd4;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_issue();
    int cnt;
    logic seen;
    availCH = 8'd8; availCD = 12'd64;
    txIf.i_TxRdReady = 1'b0;
    reqAddr[0 +: 64] = 64'h1000; reqLen[0 +: 10] = 10'd16; reqValid[0] = 1'b1;
    cnt = 0;
    while (!txIf.o_TxRdValid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    nTotal++;
    if (txIf.o_TxRdValid !== 1'b1 || txIf.o5_TxRdTag === 5'd0)
      $display("FAIL rst_pre_state: got valid %b tag %0d expected valid 1 tag nonzero",
               txIf.o_TxRdValid, txIf.o5_TxRdTag);
    else nPass++;
    #2;
    rstN = 1'b0;
    #1;
    nTotal++;
    if (txIf.o_TxRdValid !== 1'b0 || txIf.o5_TxRdTag !== 5'd0 || txIf.o64_TxRdAddr !== 64'h0 ||
        txIf.o10_TxRdLen !== 10'd0 || txIf.o3_TxRdSrc !== 3'd0 || ack !== 2'b00 || submit !== 2'b00)
      $display("FAIL rst_async_clear: got valid %b tag %0d addr %0h len %0d src %0d ack %b sub %b expected all 0",
               txIf.o_TxRdValid, txIf.o5_TxRdTag, txIf.o64_TxRdAddr, txIf.o10_TxRdLen,
               txIf.o3_TxRdSrc, ack, submit);
    else nPass++;
    reqValid = 2'b00;
    txIf.i_TxRdReady = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | (|ack) | (|submit) | txIf.o_TxRdValid;
    end
    nTotal++;
    if (seen !== 1'b0) $display("FAIL rst_no_activity: got %b expected 0", seen);
    else nPass++;
    expTag = 5'd0;
    issue_one(0, 64'h1000, 10'd16, 8'd1, 12'd4, 3, "rst_regrant");
  endtask

  task automatic test_infinite_credit();
    availCH = 8'd8; availCD = 12'd0;
    totalCH = 8'd8; totalCD = 12'd0;
    txIf.i_TxRdReady = 1'b1;
`ifdef MEM_RD_CREDIT_GATE_INFINITE_EN
    issue_one(0, 64'h1000, 10'd16, 8'd1, 12'd4, 3, "infinite_cd");
`else
    begin
      logic seen;
      reqAddr[0 +: 64] = 64'h1000; reqLen[0 +: 10] = 10'd16; reqValid[0] = 1'b1;
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        seen = seen | txIf.o_TxRdValid | (|ack);
      end
      nTotal++;
      if (seen !== 1'b0) $display("FAIL finite_cd_stall: got %b expected 0", seen);
      else nPass++;
      rstN = 1'b0;
      reqValid = 2'b00;
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_calc();
    test_credit_stall();
    test_back_to_back();
    test_reset_mid_issue();
    test_infinite_credit();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
